// File: rtl/rv_pkg.sv
// Shared types for the 3-stage RV32I core: opcodes, decode enums,
// pipeline register layouts and small decode helpers.
package rv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_type_e;

  typedef enum logic [1:0] {OPA_RS1, OPA_PC, OPA_ZERO} opa_sel_e;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
  } ifdx_t;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_write;
    wb_sel_e     wb_sel;
    logic [4:0]  rd;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [31:0] pc4;
  } dxwb_t;

  // Sign-extended immediate for each RV32I instruction format
  function automatic logic [31:0] imm_gen(input logic [31:0] inst, input imm_type_e kind);
    case (kind)
      IMM_I:   return {{20{inst[31]}}, inst[31:20]};
      IMM_S:   return {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   return {inst[31:12], 12'b0};
      IMM_J:   return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  // funct3 to ALU operation; alt selects SUB/SRA where funct7[5] applies
  function automatic alu_op_e alu_decode(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv3stage_processor_alu.sv
// 32-bit integer ALU with wrap-around arithmetic and 5-bit shift amounts.
module alu
  import rv_pkg::*;
(
  input  alu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  // Pure combinational operation select
  always_comb begin
    y = 32'h0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << b[4:0];
      ALU_SLT:  y = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: y = {31'b0, a < b};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> b[4:0];
      ALU_SRA:  y = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = 32'h0;
    endcase
  end

endmodule

// File: rtl/rv3stage_processor_inst_mem.sv
// Instruction memory: word array with a combinational read port.
// The write port exists for in-system loading and is tied off at the top.
module inst_mem
  import rv_pkg::*;
#(
  parameter int WORDS = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(WORDS)-1:0] waddr,
  input  logic [31:0]              wdata,
  input  logic [31:0]              addr,
  output logic [31:0]              data
);

  localparam int AW = $clog2(WORDS);

  logic [31:0] mem [WORDS];
  logic        unused_addr;

  // Byte-offset bits and bits beyond the depth do not select a word
  assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
  assign data = mem[addr[AW+1:2]];

  // Optional word write for loading programs
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

endmodule

// File: rtl/rv3stage_processor_reg_file.sv
// 32 x 32-bit register file, two combinational read ports and one write
// port. x0 always reads zero and ignores writes. Contents are not reset.
module reg_file (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] reg_mem [32];

  assign rdata1 = (raddr1 == 5'd0) ? 32'h0 : reg_mem[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'h0 : reg_mem[raddr2];

  // Retire a result into the array, never touching x0
  always_ff @(posedge clk) begin
    if (we && (waddr != 5'd0)) reg_mem[waddr] <= wdata;
  end

endmodule

// File: rtl/rv3stage_processor.sv
// RV32I core, 3 stages: IF | DX (decode+execute) | WB (memory+writeback).
// Control transfers resolve in DX with one bubble; WB results forward into
// DX so the pipeline never stalls. Memory depths must be powers of two.
module rv3stage_processor
  import rv_pkg::*;
#(
  parameter int          IMEM_WORDS = 1024,
  parameter int          DMEM_WORDS = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input logic clk,
  input logic rst
);

  localparam int DA = $clog2(DMEM_WORDS);

  logic [31:0] pc, inst;
  ifdx_t       ifdx, ifdx_next;
  dxwb_t       dxwb, dx_out;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic        funct7b5;

  imm_type_e   imm_type;
  alu_op_e     alu_op;
  opa_sel_e    opa_sel;
  wb_sel_e     wb_sel;
  logic        use_imm, reg_write, mem_write, is_branch, is_jal, is_jalr;

  logic [31:0] imm, rf_rd1, rf_rd2, rs1_val, rs2_val, alu_a, alu_b, alu_y;
  logic [31:0] target, wb_result, load_data;
  logic        fwd1, fwd2, taken, redirect, rf_we;

  logic [31:0] dmem [DMEM_WORDS];

  inst_mem #(.WORDS(IMEM_WORDS)) inst_mem_i (
    .clk   (clk),
    .we    (1'b0),
    .waddr ('0),
    .wdata ('0),
    .addr  (pc),
    .data  (inst)
  );

  assign opcode   = ifdx.inst[6:0];
  assign rd       = ifdx.inst[11:7];
  assign funct3   = ifdx.inst[14:12];
  assign rs1      = ifdx.inst[19:15];
  assign rs2      = ifdx.inst[24:20];
  assign funct7b5 = ifdx.inst[30];

  // Decode the DX instruction into control fields; unknown opcodes stay NOP
  always_comb begin
    imm_type  = IMM_NONE;
    alu_op    = ALU_ADD;
    opa_sel   = OPA_RS1;
    wb_sel    = WB_ALU;
    use_imm   = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    case (opcode)
      OPC_LUI: begin
        imm_type = IMM_U; opa_sel = OPA_ZERO; use_imm = 1'b1; reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        imm_type = IMM_U; opa_sel = OPA_PC; use_imm = 1'b1; reg_write = 1'b1;
      end
      OPC_JAL: begin
        imm_type = IMM_J; is_jal = 1'b1; reg_write = 1'b1; wb_sel = WB_PC4;
      end
      OPC_JALR: begin
        if (funct3 == 3'b000) begin
          imm_type = IMM_I; use_imm = 1'b1; is_jalr = 1'b1;
          reg_write = 1'b1; wb_sel = WB_PC4;
        end
      end
      OPC_BRANCH: begin
        imm_type = IMM_B; is_branch = 1'b1;
      end
      OPC_LOAD: begin
        if (funct3 == 3'b010) begin
          imm_type = IMM_I; use_imm = 1'b1; reg_write = 1'b1; wb_sel = WB_MEM;
        end
      end
      OPC_STORE: begin
        if (funct3 == 3'b010) begin
          imm_type = IMM_S; use_imm = 1'b1; mem_write = 1'b1;
        end
      end
      OPC_OPIMM: begin
        imm_type  = IMM_I;
        use_imm   = 1'b1;
        reg_write = 1'b1;
        alu_op    = alu_decode(funct3, funct7b5 && (funct3 == 3'b101));
      end
      OPC_OP: begin
        reg_write = 1'b1;
        alu_op    = alu_decode(funct3, funct7b5);
      end
      default: begin
      end
    endcase
  end

  reg_file reg_file_i (
    .clk    (clk),
    .we     (rf_we),
    .waddr  (dxwb.rd),
    .wdata  (wb_result),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rf_rd1),
    .rdata2 (rf_rd2)
  );

  // A WB instruction writing a non-zero rd supplies its result to DX
  assign fwd1    = dxwb.valid && dxwb.reg_write && (dxwb.rd != 5'd0) && (dxwb.rd == rs1);
  assign fwd2    = dxwb.valid && dxwb.reg_write && (dxwb.rd != 5'd0) && (dxwb.rd == rs2);
  assign rs1_val = fwd1 ? wb_result : rf_rd1;
  assign rs2_val = fwd2 ? wb_result : rf_rd2;
  assign imm     = imm_gen(ifdx.inst, imm_type);

  // Select ALU operands
  always_comb begin
    alu_a = rs1_val;
    case (opa_sel)
      OPA_PC:   alu_a = ifdx.pc;
      OPA_ZERO: alu_a = 32'h0;
      default:  alu_a = rs1_val;
    endcase
    alu_b = use_imm ? imm : rs2_val;
  end

  alu alu_i (
    .op (alu_op),
    .a  (alu_a),
    .b  (alu_b),
    .y  (alu_y)
  );

  // Evaluate the branch condition from the forwarded operands
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = (rs1_val == rs2_val);
      3'b001:  taken = (rs1_val != rs2_val);
      3'b100:  taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  taken = (rs1_val <  rs2_val);
      3'b111:  taken = (rs1_val >= rs2_val);
      default: taken = 1'b0;
    endcase
  end

  assign target   = is_jalr ? {alu_y[31:1], 1'b0} : (ifdx.pc + imm);
  assign redirect = ifdx.valid && (is_jal || is_jalr || (is_branch && taken));

  // Build the next pipeline register contents for IF/DX and DX/WB
  always_comb begin
    ifdx_next       = '0;
    ifdx_next.valid = 1'b1;
    ifdx_next.pc    = pc;
    ifdx_next.inst  = inst;
    dx_out            = '0;
    dx_out.valid      = ifdx.valid;
    dx_out.reg_write  = ifdx.valid && reg_write;
    dx_out.mem_write  = ifdx.valid && mem_write;
    dx_out.wb_sel     = wb_sel;
    dx_out.rd         = rd;
    dx_out.alu_result = alu_y;
    dx_out.store_data = rs2_val;
    dx_out.pc4        = ifdx.pc + 32'd4;
  end

  // Advance PC and pipeline registers; a redirect squashes the fetched slot
  always_ff @(posedge clk) begin
    if (rst) begin
      pc   <= RESET_PC;
      ifdx <= '0;
      dxwb <= '0;
    end else begin
      pc   <= redirect ? target : (pc + 32'd4);
      ifdx <= redirect ? '0 : ifdx_next;
      dxwb <= dx_out;
    end
  end

  assign load_data = dmem[dxwb.alu_result[DA+1:2]];

  // Pick the value the WB instruction retires
  always_comb begin
    wb_result = dxwb.alu_result;
    case (dxwb.wb_sel)
      WB_MEM:  wb_result = load_data;
      WB_PC4:  wb_result = dxwb.pc4;
      default: wb_result = dxwb.alu_result;
    endcase
  end

  assign rf_we = !rst && dxwb.valid && dxwb.reg_write && (dxwb.rd != 5'd0);

  // Commit stores at the end of WB unless reset discards the instruction
  always_ff @(posedge clk) begin
    if (!rst && dxwb.valid && dxwb.mem_write)
      dmem[dxwb.alu_result[DA+1:2]] <= dxwb.store_data;
  end

endmodule

// File: tb/tb_rv3stage_processor.sv
// Program-level bench for the 3-stage core: preloads memories, runs short
// programs and scores expected register results queued with each program.
module tb_rv3stage_processor;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int          idx;
    logic [31:0] val;
  } exp_t;

  exp_t        sbq[$];
  exp_t        e;
  logic [31:0] snap [32];

  rv3stage_processor #(
    .IMEM_WORDS (1024),
    .DMEM_WORDS (1024),
    .RESET_PC   (32'h0)
  ) dut (
    .clk (clk),
    .rst (rst)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] opc);
    logic [31:0] im, a, f, d;
    im = imm; a = rs1; f = f3; d = rd;
    return {im[11:0], a[4:0], f[2:0], d[4:0], opc};
  endfunction

  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return enc_i(imm, rs1, 0, rd, 7'b0010011);
  endfunction

  function automatic logic [31:0] enc_r(input int alt, input int rs2, input int rs1, input int f3, input int rd);
    logic [31:0] b, a, f, d;
    b = rs2; a = rs1; f = f3; d = rd;
    return {1'b0, alt[0], 5'b0, b[4:0], a[4:0], f[2:0], d[4:0], 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
    logic [31:0] im, b, a;
    im = imm; b = rs2; a = rs1;
    return {im[11:5], b[4:0], a[4:0], 3'b010, im[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] im, b, a, f;
    im = imm; b = rs2; a = rs1; f = f3;
    return {im[12], im[10:5], b[4:0], a[4:0], f[2:0], im[4:1], im[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [31:0] im, d;
    im = imm; d = rd;
    return {im[20], im[10:1], im[11], im[19:12], d[4:0], 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_u(input int imm20, input int rd, input logic [6:0] opc);
    logic [31:0] im, d;
    im = imm20; d = rd;
    return {im[19:0], d[4:0], opc};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 1024; i++) dut.inst_mem_i.mem[i] = 32'h00000013;
  endtask

  task automatic put(input int byte_addr, input logic [31:0] w);
    dut.inst_mem_i.mem[byte_addr / 4] = w;
  endtask

  task automatic set_reg(input int idx, input logic [31:0] v);
    dut.reg_file_i.reg_mem[idx] = v;
  endtask

  task automatic do_reset(input int edges);
    @(negedge clk);
    rst = 1'b1;
    repeat (edges) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear_imem();
    set_reg(5, 32'hA5A5A5A5);
    set_reg(8, 32'h0);
    put(0, addi(8, 0, 32'h11));
    sbq.push_back('{5, 32'hA5A5A5A5});
    sbq.push_back('{8, 32'h00000011});
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (dut.reg_file_i.reg_mem[5] !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL reset_hold x5 got %h expected %h", dut.reg_file_i.reg_mem[5], 32'hA5A5A5A5);
    end
    rst = 1'b0;
    run(10);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      if (dut.reg_file_i.reg_mem[e.idx] !== e.val) begin
        errors++;
        $display("FAIL reset x%0d got %h expected %h", e.idx, dut.reg_file_i.reg_mem[e.idx], e.val);
      end
    end
  endtask

  task automatic test_back_to_back();
    int first_edge;
    logic [31:0] final_exp [4];
    clear_imem();
    for (int r = 1; r <= 4; r++) set_reg(r, 32'h0);
    put(0,  addi(1, 0, 5));
    put(4,  addi(2, 0, 7));
    put(8,  enc_r(0, 2, 1, 0, 3));
    put(12, enc_r(1, 1, 2, 0, 4));
    sbq.push_back('{1, 32'd5});
    sbq.push_back('{2, 32'd7});
    sbq.push_back('{3, 32'd12});
    sbq.push_back('{4, 32'd2});
    final_exp[0] = 32'd5; final_exp[1] = 32'd7; final_exp[2] = 32'd12; final_exp[3] = 32'd2;
    do_reset(1);
    for (int r = 0; r < 32; r++) snap[r] = dut.reg_file_i.reg_mem[r];
    first_edge = -1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      for (int r = 0; r < 32; r++) begin
        if (dut.reg_file_i.reg_mem[r] !== snap[r]) begin
          if (first_edge < 0) first_edge = cyc;
          checks++;
          if (sbq.size() == 0) begin
            errors++;
            $display("FAIL b2b_extra_write x%0d got %h expected no write", r, dut.reg_file_i.reg_mem[r]);
          end else begin
            e = sbq.pop_front();
            if (r != e.idx || dut.reg_file_i.reg_mem[r] !== e.val) begin
              errors++;
              $display("FAIL b2b_retire got x%0d=%h expected x%0d=%h", r, dut.reg_file_i.reg_mem[r], e.idx, e.val);
            end
          end
          snap[r] = dut.reg_file_i.reg_mem[r];
        end
      end
    end
    checks++;
    if (first_edge != 3) begin
      errors++;
      $display("FAIL b2b_first_retire edge got %0d expected 3", first_edge);
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL b2b_missing_writes got %0d pending expected 0", sbq.size());
      sbq.delete();
    end
    for (int r = 1; r <= 4; r++) begin
      checks++;
      if (dut.reg_file_i.reg_mem[r] !== final_exp[r-1]) begin
        errors++;
        $display("FAIL b2b_final x%0d got %h expected %h", r, dut.reg_file_i.reg_mem[r], final_exp[r-1]);
      end
    end
  endtask

  task automatic test_load_store();
    clear_imem();
    for (int r = 1; r <= 5; r++) set_reg(r, 32'h0);
    set_reg(9, 32'h0);
    put(0,  addi(1, 0, 32'h40));
    put(4,  addi(2, 0, -3));
    put(8,  enc_s(0, 2, 1));
    put(12, enc_i(0, 1, 2, 3, 7'b0000011));
    put(16, enc_r(0, 3, 3, 0, 4));
    put(20, enc_u(1, 9, 7'b0110111));
    put(24, enc_r(0, 1, 9, 0, 9));
    put(28, enc_i(3, 9, 2, 5, 7'b0000011));
    sbq.push_back('{1, 32'h00000040});
    sbq.push_back('{2, 32'hFFFFFFFD});
    sbq.push_back('{3, 32'hFFFFFFFD});
    sbq.push_back('{4, 32'hFFFFFFFA});
    sbq.push_back('{9, 32'h00001040});
    sbq.push_back('{5, 32'hFFFFFFFD});
    do_reset(1);
    run(30);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      if (dut.reg_file_i.reg_mem[e.idx] !== e.val) begin
        errors++;
        $display("FAIL load_store x%0d got %h expected %h", e.idx, dut.reg_file_i.reg_mem[e.idx], e.val);
      end
    end
  endtask

  task automatic test_branch_flush();
    clear_imem();
    set_reg(6, 32'h66);  set_reg(7, 32'h0);   set_reg(10, 32'h0);
    set_reg(12, 32'h0);  set_reg(13, 32'h13); set_reg(14, 32'h0);
    set_reg(15, 32'h0);
    put(0,  enc_b(8, 0, 0, 0));
    put(4,  addi(6, 0, 1));
    put(8,  addi(7, 0, 9));
    put(12, enc_b(8, 0, 0, 1));
    put(16, addi(10, 0, 3));
    put(20, addi(12, 0, -1));
    put(24, enc_b(8, 12, 0, 6));
    put(28, addi(13, 0, 1));
    put(32, addi(14, 0, 2));
    put(36, enc_b(8, 12, 0, 4));
    put(40, addi(15, 0, 4));
    sbq.push_back('{6,  32'h00000066});
    sbq.push_back('{7,  32'h00000009});
    sbq.push_back('{10, 32'h00000003});
    sbq.push_back('{12, 32'hFFFFFFFF});
    sbq.push_back('{13, 32'h00000013});
    sbq.push_back('{14, 32'h00000002});
    sbq.push_back('{15, 32'h00000004});
    do_reset(1);
    run(30);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      if (dut.reg_file_i.reg_mem[e.idx] !== e.val) begin
        errors++;
        $display("FAIL branch x%0d got %h expected %h", e.idx, dut.reg_file_i.reg_mem[e.idx], e.val);
      end
    end
  endtask

  task automatic test_jal();
    clear_imem();
    set_reg(0, 32'h0);   set_reg(1, 32'h0);   set_reg(17, 32'h17);
    set_reg(18, 32'h0);  set_reg(19, 32'h19); set_reg(20, 32'h0);
    put(32'h10, enc_j(8, 1));
    put(32'h14, addi(0, 0, 5));
    put(32'h18, addi(0, 0, 5));
    put(32'h1C, enc_r(0, 0, 0, 0, 17));
    put(32'h20, enc_i(32'h31, 0, 0, 18, 7'b1100111));
    put(32'h24, addi(19, 0, 1));
    put(32'h30, addi(20, 0, 5));
    sbq.push_back('{1,  32'h00000014});
    sbq.push_back('{0,  32'h00000000});
    sbq.push_back('{17, 32'h00000000});
    sbq.push_back('{18, 32'h00000024});
    sbq.push_back('{19, 32'h00000019});
    sbq.push_back('{20, 32'h00000005});
    do_reset(1);
    run(30);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      if (dut.reg_file_i.reg_mem[e.idx] !== e.val) begin
        errors++;
        $display("FAIL jal x%0d got %h expected %h", e.idx, dut.reg_file_i.reg_mem[e.idx], e.val);
      end
    end
  endtask

  task automatic test_mid_reset();
    clear_imem();
    set_reg(1, 32'h0);  set_reg(2, 32'h0);
    set_reg(22, 32'h0); set_reg(23, 32'h23);
    put(0, addi(1, 0, 32'h55));
    put(4, enc_s(32'h80, 1, 0));
    do_reset(1);
    run(10);
    clear_imem();
    put(0, addi(2, 0, 32'h77));
    put(4, enc_s(32'h80, 2, 0));
    put(8, addi(23, 0, 1));
    sbq.push_back('{2,  32'h00000077});
    sbq.push_back('{22, 32'h00000055});
    sbq.push_back('{23, 32'h00000023});
    do_reset(1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear_imem();
    put(0, enc_i(32'h80, 0, 2, 22, 7'b0000011));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run(10);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      if (dut.reg_file_i.reg_mem[e.idx] !== e.val) begin
        errors++;
        $display("FAIL mid_reset x%0d got %h expected %h", e.idx, dut.reg_file_i.reg_mem[e.idx], e.val);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_back_to_back();
    test_load_store();
    test_branch_flush();
    test_jal();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
